// File: rtl/branch_predictor_unit.sv
// Branch predictor: 16-entry BHT of 2-bit counters, 16-entry direct-mapped BTB, 4-bit GHR.
// Define BP_GSHARE_EN to index the BHT with PC[3:0] XOR global history.
module branch_predictor_unit #(
    parameter logic [1:0] BHT_INIT = 2'b01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] fetch_pc,
    output logic       predict_taken,
    output logic [7:0] predict_target,
    output logic [3:0] predict_ghr,
    input  logic       update,
    input  logic [7:0] update_pc,
    input  logic       update_taken,
    input  logic [7:0] update_target,
    input  logic [3:0] update_ghr
);

    logic [15:0][1:0] bht_q, bht_d;
    logic [15:0]      vld_q, vld_d;
    logic [15:0][3:0] tag_q, tag_d;
    logic [15:0][7:0] tgt_q, tgt_d;
    logic [3:0]       ghr_q, ghr_d;

    logic [3:0] lk_idx;
    logic [3:0] up_idx;
    logic [3:0] btb_lk;
    logic [3:0] btb_up;
    logic       hit;
    logic [1:0] cnt;

    assign btb_lk = fetch_pc[3:0];
    assign btb_up = update_pc[3:0];

`ifdef BP_GSHARE_EN
    assign lk_idx = fetch_pc[3:0] ^ ghr_q;
    assign up_idx = update_pc[3:0] ^ update_ghr;
`else
    logic unused_ghr;
    assign unused_ghr = ^update_ghr;
    assign lk_idx = fetch_pc[3:0];
    assign up_idx = update_pc[3:0];
`endif

    // Lookup reads only registered state, so a same-cycle update is not bypassed.
    always_comb begin
        hit            = vld_q[btb_lk] && (tag_q[btb_lk] == fetch_pc[7:4]);
        predict_taken  = hit && bht_q[lk_idx][1];
        predict_target = predict_taken ? tgt_q[btb_lk] : fetch_pc + 8'd1;
        predict_ghr    = ghr_q;
    end

    always_comb begin
        bht_d = bht_q;
        vld_d = vld_q;
        tag_d = tag_q;
        tgt_d = tgt_q;
        ghr_d = ghr_q;
        cnt   = bht_q[up_idx];
        if (update) begin
            if (update_taken && cnt != 2'b11) begin
                cnt = cnt + 2'd1;
            end else if (!update_taken && cnt != 2'b00) begin
                cnt = cnt - 2'd1;
            end
            bht_d[up_idx] = cnt;
            if (update_taken) begin
                vld_d[btb_up] = 1'b1;
                tag_d[btb_up] = update_pc[7:4];
                tgt_d[btb_up] = update_target;
            end
            ghr_d = {ghr_q[2:0], update_taken};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bht_q <= {16{BHT_INIT}};
            vld_q <= '0;
            ghr_q <= '0;
        end else begin
            bht_q <= bht_d;
            vld_q <= vld_d;
            ghr_q <= ghr_d;
        end
    end

    // Tag and target payload are qualified by valid; reset would drop any coincident write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_q <= tag_d;
            tgt_q <= tgt_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed self-checking bench for branch_predictor_unit.
// Checks the default build, or the gshare behaviour when BP_GSHARE_EN is defined.
module tb_branch_predictor_unit;

    logic       clk;
    logic       reset;
    logic [7:0] fetch_pc;
    logic       predict_taken;
    logic [7:0] predict_target;
    logic [3:0] predict_ghr;
    logic       update;
    logic [7:0] update_pc;
    logic       update_taken;
    logic [7:0] update_target;
    logic [3:0] update_ghr;

    int vecs;
    int fails;

    branch_predictor_unit dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_pc       (fetch_pc),
        .predict_taken  (predict_taken),
        .predict_target (predict_target),
        .predict_ghr    (predict_ghr),
        .update         (update),
        .update_pc      (update_pc),
        .update_taken   (update_taken),
        .update_target  (update_target),
        .update_ghr     (update_ghr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [7:0] pc, input logic tk, input logic [7:0] tg,
                       input logic [3:0] gh);
        update        = 1'b1;
        update_pc     = pc;
        update_taken  = tk;
        update_target = tg;
        update_ghr    = gh;
        tick();
        update        = 1'b0;
    endtask

    task automatic look(input string tag, input logic [7:0] pc, input logic tk,
                        input logic [7:0] tg);
        fetch_pc = pc;
        #1;
        check({tag, "_taken"}, {7'd0, predict_taken}, {7'd0, tk});
        check({tag, "_target"}, predict_target, tg);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        update = 1'b0;
        tick();
        tick();
        reset  = 1'b0;
    endtask

    initial begin
        vecs          = 0;
        fails         = 0;
        reset         = 1'b1;
        fetch_pc      = 8'h00;
        update        = 1'b0;
        update_pc     = 8'h00;
        update_taken  = 1'b0;
        update_target = 8'h00;
        update_ghr    = 4'h0;

        do_reset();
        look("rst_10", 8'h10, 1'b0, 8'h11);
        check("rst_ghr", {4'd0, predict_ghr}, 8'h00);
        look("rst_ff", 8'hFF, 1'b0, 8'h00);

`ifdef BP_GSHARE_EN
        upd(8'h01, 1'b1, 8'h10, 4'h0);
        upd(8'h01, 1'b1, 8'h10, 4'h1);
        upd(8'h01, 1'b1, 8'h10, 4'h3);
        check("gs_ghr7", {4'd0, predict_ghr}, 8'h07);
        upd(8'h24, 1'b1, 8'h50, 4'h7);
        upd(8'h24, 1'b1, 8'h50, 4'h7);
        check("gs_ghrF", {4'd0, predict_ghr}, 8'h0F);
        look("gs_ghrF_24", 8'h24, 1'b0, 8'h25);
        upd(8'h0C, 1'b0, 8'h00, 4'h0);
        upd(8'h0D, 1'b1, 8'h60, 4'h0);
        upd(8'h0D, 1'b1, 8'h60, 4'h0);
        upd(8'h0D, 1'b1, 8'h60, 4'h0);
        check("gs_ghr7b", {4'd0, predict_ghr}, 8'h07);
        look("gs_ghr7_24", 8'h24, 1'b1, 8'h50);
        upd(8'h0E, 1'b0, 8'h00, 4'h0);
        check("gs_ghrE", {4'd0, predict_ghr}, 8'h0E);
        look("gs_ghrE_24", 8'h24, 1'b0, 8'h25);
`else
        // Train, then alias on the tag
        upd(8'h24, 1'b1, 8'h50, 4'h0);
        upd(8'h24, 1'b1, 8'h50, 4'h0);
        look("hit_24", 8'h24, 1'b1, 8'h50);
        check("ghr_3", {4'd0, predict_ghr}, 8'h03);
        look("alias_34", 8'h34, 1'b0, 8'h35);

        // Saturate at 11, then walk down
        repeat (5) upd(8'h24, 1'b1, 8'h50, 4'h0);
        check("ghr_F", {4'd0, predict_ghr}, 8'h0F);
        upd(8'h24, 1'b0, 8'h00, 4'h0);
        look("sat_nt1", 8'h24, 1'b1, 8'h50);
        upd(8'h24, 1'b0, 8'h00, 4'h0);
        look("sat_nt2", 8'h24, 1'b0, 8'h25);
        check("ghr_C", {4'd0, predict_ghr}, 8'h0C);

        // Same-cycle update and lookup sees the old state
        do_reset();
        fetch_pc      = 8'h24;
        update        = 1'b1;
        update_pc     = 8'h24;
        update_taken  = 1'b1;
        update_target = 8'h50;
        #1;
        check("same_cyc_old", {7'd0, predict_taken}, 8'h00);
        tick();
        tick();
        update = 1'b0;
        look("same_cyc_new", 8'h24, 1'b1, 8'h50);

        // Reset beats a coincident update
        reset         = 1'b1;
        update        = 1'b1;
        update_pc     = 8'h38;
        update_taken  = 1'b1;
        update_target = 8'h77;
        tick();
        reset  = 1'b0;
        update = 1'b0;
        look("rupd_24", 8'h24, 1'b0, 8'h25);
        look("rupd_38", 8'h38, 1'b0, 8'h39);
        check("rupd_ghr", {4'd0, predict_ghr}, 8'h00);
        upd(8'h24, 1'b1, 8'h50, 4'h0);
        look("init_wnt", 8'h24, 1'b1, 8'h50);

        // History has no effect on the index
        repeat (3) upd(8'h05, 1'b0, 8'h00, 4'h0);
        check("ghr_8", {4'd0, predict_ghr}, 8'h08);
        look("hist_indep", 8'h24, 1'b1, 8'h50);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
